// File: rtl/clock_gate_ctrl_if.sv
// Handshake bundle between the clock-gate sequencer and its subdomain.
// master = sequencer side, slave = domain/requester side.
interface clock_gate_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
);
  logic [NUM_REQ-1:0] wake_req_i;
  logic               busy_i;
  logic               force_on_i;
  logic               quiesce_ack_i;
  logic               quiesce_req_o;
  logic               clk_en_o;
  logic               ready_o;
  logic               gated_o;
  logic [CNT_W-1:0]   gate_cnt_o;

  modport master (
    input  wake_req_i, busy_i, force_on_i, quiesce_ack_i,
    output quiesce_req_o, clk_en_o, ready_o, gated_o, gate_cnt_o
  );

  modport slave (
    output wake_req_i, busy_i, force_on_i, quiesce_ack_i,
    input  quiesce_req_o, clk_en_o, ready_o, gated_o, gate_cnt_o
  );
endinterface

// File: rtl/clock_gate_ctrl.sv
// Idle-driven enable sequencer for one subdomain ClockGate.
// Every output is a flop so the gate enable can never glitch.
module clock_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  clock_gate_ctrl_if.master   io
);

  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] GATED = 2'd2;
  localparam logic [1:0] WAKE  = 2'd3;

  logic [NUM_REQ-1:0] req;
  logic               idle;
  logic               demand;

  logic [1:0]        state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic              clk_en_q, clk_en_d;
  logic              ready_q, ready_d;
  logic              qreq_q, qreq_d;
  logic              gated_q, gated_d;

  assign req    = io.wake_req_i;
  assign demand = (|req) || io.force_on_i;
  assign idle   = !io.busy_i && !demand;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_cnt_d = gate_cnt_q;
    unique case (state_q)
      RUN: begin
        if (!idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d = DRAIN;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      DRAIN: begin
        // abort wins over a same-cycle ack
        if (!idle) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (io.quiesce_ack_i) begin
          state_d = GATED;
          if (gate_cnt_q != {CNT_W{1'b1}})
            gate_cnt_d = gate_cnt_q + CNT_W'(1);
        end
      end
      GATED: begin
        if (demand) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    clk_en_d = (state_d != GATED);
    ready_d  = (state_d == RUN) || (state_d == DRAIN);
    qreq_d   = (state_d == DRAIN) || (state_d == GATED);
    gated_d  = (state_d == GATED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      gate_cnt_q <= '0;
      clk_en_q   <= 1'b1;
      ready_q    <= 1'b1;
      qreq_q     <= 1'b0;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      clk_en_q   <= clk_en_d;
      ready_q    <= ready_d;
      qreq_q     <= qreq_d;
      gated_q    <= gated_d;
    end
  end

  assign io.clk_en_o      = clk_en_q;
  assign io.ready_o       = ready_q;
  assign io.quiesce_req_o = qreq_q;
  assign io.gated_o       = gated_q;
  assign io.gate_cnt_o    = gate_cnt_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Bench for clock_gate_ctrl: directed test-plan sequences plus
// randomized traffic checked cycle-by-cycle against a phase model.
module tb_clock_gate_ctrl;

  localparam int NREQ = 4;
  localparam int IDLE = 4;
  localparam int WAKE = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  clock_gate_ctrl_if #(.NUM_REQ(NREQ), .CNT_W(CW)) bus ();

  clock_gate_ctrl #(
    .NUM_REQ(NREQ), .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE), .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .io(bus)
  );

  always #5 clk = ~clk;

  typedef enum {M_RUN, M_DRAIN, M_GATED, M_WAKE} mphase_t;
  mphase_t ph = M_RUN;
  int idle_run = 0;
  int wake_age = 0;
  int m_gates  = 0;

  wire m_idle = !bus.busy_i && (bus.wake_req_i == '0) && !bus.force_on_i;
  wire m_dem  = (bus.wake_req_i != '0) || bus.force_on_i;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= M_RUN; idle_run <= 0; wake_age <= 0; m_gates <= 0;
    end else begin
      case (ph)
        M_RUN: begin
          if (!m_idle) idle_run <= 0;
          else begin
            idle_run <= idle_run + 1;
            if (idle_run + 1 == IDLE) ph <= M_DRAIN;
          end
        end
        M_DRAIN: begin
          if (!m_idle) begin ph <= M_RUN; idle_run <= 0; end
          else if (bus.quiesce_ack_i) begin
            ph <= M_GATED; m_gates <= m_gates + 1;
          end
        end
        M_GATED: if (m_dem) begin ph <= M_WAKE; wake_age <= 0; end
        M_WAKE: begin
          wake_age <= wake_age + 1;
          if (wake_age + 1 == WAKE) begin ph <= M_RUN; idle_run <= 0; end
        end
      endcase
    end
  end

  logic [5:0] exp_v, act_v;
  always @(negedge clk) begin
    exp_v[5] = (ph != M_GATED);
    exp_v[4] = (ph == M_RUN) || (ph == M_DRAIN);
    exp_v[3] = (ph == M_DRAIN) || (ph == M_GATED);
    exp_v[2] = (ph == M_GATED);
    exp_v[1:0] = CW'((m_gates > CMAX) ? CMAX : m_gates);
    act_v = {bus.clk_en_o, bus.ready_o, bus.quiesce_req_o,
             bus.gated_o, bus.gate_cnt_o};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t {en,rdy,qreq,gated,cnt} actual=%b required=%b",
               $time, act_v, exp_v);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_in(logic [NREQ-1:0] w, logic b, logic f, logic a);
    bus.wake_req_i = w;
    bus.busy_i = b;
    bus.force_on_i = f;
    bus.quiesce_ack_i = a;
  endtask

  initial begin
    set_in('0, 1'b0, 1'b0, 1'b0);
    cyc(2);
    chk("rst_clk_en", bus.clk_en_o, 1);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_qreq", bus.quiesce_req_o, 0);
    chk("rst_gated", bus.gated_o, 0);
    chk("rst_cnt", bus.gate_cnt_o, 0);

    // idle from release, ack tied high
    set_in('0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cyc(3);
    chk("gate_qreq_early", bus.quiesce_req_o, 0);
    cyc(1);
    chk("gate_qreq_rise", bus.quiesce_req_o, 1);
    chk("gate_en_in_drain", bus.clk_en_o, 1);
    cyc(1);
    chk("gate_en_low", bus.clk_en_o, 0);
    chk("gate_gated", bus.gated_o, 1);
    chk("gate_cnt1", bus.gate_cnt_o, 1);

    // one-cycle wake pulse
    set_in(4'b0001, 1'b0, 1'b0, 1'b1);
    cyc(1);
    chk("wake_en", bus.clk_en_o, 1);
    chk("wake_ready0", bus.ready_o, 0);
    chk("wake_qreq", bus.quiesce_req_o, 0);
    set_in('0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk("wake_ready1", bus.ready_o, 0);
    cyc(1);
    chk("wake_ready_up", bus.ready_o, 1);

    // abort beats ack in DRAIN
    cyc(4);
    chk("abort_in_drain", bus.quiesce_req_o, 1);
    set_in(4'b0100, 1'b0, 1'b0, 1'b1);
    cyc(1);
    chk("abort_qreq", bus.quiesce_req_o, 0);
    chk("abort_en", bus.clk_en_o, 1);
    chk("abort_cnt", bus.gate_cnt_o, 1);

    // busy at idle cycle 3 restarts the count
    set_in('0, 1'b0, 1'b0, 1'b1);
    cyc(2);
    bus.busy_i = 1'b1;
    cyc(1);
    bus.busy_i = 1'b0;
    cyc(3);
    chk("busy_no_drain", bus.quiesce_req_o, 0);
    cyc(1);
    chk("busy_drain", bus.quiesce_req_o, 1);
    cyc(1);
    chk("busy_gated_cnt", bus.gate_cnt_o, 2);

    // force_on wakes and then holds the clock on
    bus.force_on_i = 1'b1;
    cyc(1);
    chk("force_en", bus.clk_en_o, 1);
    cyc(2);
    chk("force_ready", bus.ready_o, 1);
    cyc(10);
    chk("force_hold_en", bus.clk_en_o, 1);
    chk("force_hold_qreq", bus.quiesce_req_o, 0);
    bus.force_on_i = 1'b0;

    // three more gates saturate a 2-bit counter
    for (int i = 0; i < 3; i++) begin
      cyc(5);
      if (i < 2) begin
        bus.wake_req_i = 4'b0001;
        cyc(1);
        bus.wake_req_i = '0;
        cyc(2);
      end
    end
    chk("sat_cnt", bus.gate_cnt_o, CMAX);
    chk("sat_gated", bus.gated_o, 1);

    // async reset while gated
    rst_n = 1'b0;
    #1;
    chk("arst_en", bus.clk_en_o, 1);
    chk("arst_cnt", bus.gate_cnt_o, 0);
    chk("arst_gated", bus.gated_o, 0);
    cyc(1);
    rst_n = 1'b1;

    // randomized traffic
    for (int s = 0; s < 120; s++) begin
      int mode;
      mode = $urandom_range(0, 3);
      if (mode < 2) begin
        int len;
        len = $urandom_range(1, 10);
        for (int k = 0; k < len; k++) begin
          set_in('0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
          cyc(1);
        end
      end else begin
        int len;
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++) begin
          logic [NREQ-1:0] w;
          w = ($urandom_range(0, 5) == 0) ? NREQ'($urandom_range(1, 15)) : '0;
          set_in(w, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
          cyc(1);
        end
      end
    end
    set_in('0, 1'b0, 1'b0, 1'b0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
